// File: rtl/mips_avalon_ram_slave.sv
// Avalon-MM word RAM slave for a MIPS-style memory map.
// Each transfer stalls for a fixed number of cycles. The slave records
// master misbehaviour and out-of-map accesses in sticky flags.
//
// Handshake: a transfer starts in a cycle where read|write is high and
// count == 0. The slave holds waitrequest high for WAIT_CYCLES cycles. The
// first cycle with the request high and waitrequest low is the completion
// cycle. The master must keep every request signal stable while waitrequest
// is high. A request that is still high after completion starts a new
// transfer.
module mips_avalon_ram_slave #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        protocol_error,
    output logic        decode_error
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    logic [31:0] mem [DEPTH];

    logic [3:0]  count;
    logic [31:0] lat_addr;
    logic [3:0]  lat_be;
    logic [31:0] lat_wdata;
    logic        lat_read;
    logic        lat_write;

    logic                  req;
    logic                  pending;
    logic                  first;
    logic                  complete;
    logic [31:0]           cur_addr;
    logic                  cur_read;
    logic                  cur_write;
    logic                  cur_read_only;
    logic [29:0]           word_off;
    logic                  cur_in_range;
    logic [ADDR_WIDTH-1:0] cur_index;
    logic                  req_changed;
    logic                  perr_set;

    assign req      = read | write;
    assign pending  = req && (count < WAIT_LAST);
    assign first    = req && (count == 4'd0);
    assign complete = req && (count == WAIT_LAST);

    assign waitrequest = pending;

    // The first cycle of a transfer works from the live inputs. Later cycles
    // work from the values captured in that first cycle.
    assign cur_addr      = first ? address : lat_addr;
    assign cur_read      = first ? read    : lat_read;
    assign cur_write     = first ? write   : lat_write;
    assign cur_read_only = cur_read && !cur_write;

    // Word offset from the base. A single unsigned compare on the high bits
    // also rejects addresses below the base, because they wrap around.
    assign word_off     = cur_addr[31:2] - BASE_ADDR[31:2];
    assign cur_in_range = (word_off[29:ADDR_WIDTH] == '0);
    assign cur_index    = word_off[ADDR_WIDTH-1:0];

    assign req_changed = (address != lat_addr) || (read != lat_read) ||
                         (write != lat_write) || (byteenable != lat_be) ||
                         (writedata != lat_wdata);

    assign perr_set = (req && read && write) ||
                      (pending && (count != 4'd0) && req_changed) ||
                      (!req && (count != 4'd0)) ||
                      (first && (cur_addr[1:0] != 2'b00));

    // Wait counter: counts pending cycles. It clears on completion, when the
    // request is dropped, or on reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= 4'd0;
        end else if (pending) begin
            count <= count + 4'd1;
        end else begin
            count <= 4'd0;
        end
    end

    // Capture the request in the first cycle of every transfer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_addr  <= '0;
            lat_be    <= '0;
            lat_wdata <= '0;
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
        end else if (first) begin
            lat_addr  <= address;
            lat_be    <= byteenable;
            lat_wdata <= writedata;
            lat_read  <= read;
            lat_write <= write;
        end
    end

    // Commit an in-range write lane by lane at the completion edge.
    always_ff @(posedge clk) begin
        if (reset && complete && lat_write && cur_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) begin
                    mem[cur_index][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

    // Refresh read data on every pending read cycle. Out-of-map reads return 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            readdata <= '0;
        end else if (pending && cur_read_only) begin
            readdata <= cur_in_range ? mem[cur_index] : 32'h0;
        end
    end

    // Sticky error flags. Only reset clears them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            protocol_error <= 1'b0;
            decode_error   <= 1'b0;
        end else begin
            if (perr_set) begin
                protocol_error <= 1'b1;
            end
            if (first && !cur_in_range) begin
                decode_error <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mips_avalon_ram_slave.md
MIPS_AVALON_RAM_SLAVE -- requirements
Module: mips_avalon_ram_slave

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, meaning word-index bits (depth 2^ADDR_WIDTH words).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'hBFC00000, meaning the byte address of word 0.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 2, meaning waitrequest-high cycles per transfer, legal range 1..15.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, meaning synchronous, active-low reset.
REQ-006 The block SHALL have port address, input, 32, meaning the byte address from the bus master.
REQ-007 The block SHALL have ports read and write, inputs, 1 each, meaning the transfer requests.
REQ-008 The block SHALL have port byteenable, input, 4, meaning the write lane enables; bit i maps to writedata[8i+7:8i].
REQ-009 The block SHALL have port writedata, input, 32, meaning the write data, stored as presented with no endian conversion.
REQ-010 The block SHALL have port waitrequest, output, 1, meaning the slave stall.
REQ-011 The block SHALL have port readdata, output, 32, meaning the registered read data.
REQ-012 The block SHALL have port protocol_error, output, 1, meaning a sticky master-violation flag.
REQ-013 The block SHALL have port decode_error, output, 1, meaning a sticky out-of-range-access flag.

Function
REQ-014 The block SHALL hold the memory array as 2^ADDR_WIDTH x 32-bit words, indexed by (address - BASE_ADDR) >> 2.
REQ-015 The block SHALL contain a wait counter, cleared to 0, that increments each cycle read|write is high and count < WAIT_CYCLES.
REQ-016 The block SHALL drive waitrequest = (read|write) && (count < WAIT_CYCLES) combinationally, and 0 whenever no request is present.
REQ-017 The block SHALL latch address, byteenable and writedata in the first cycle of a transfer (count == 0) and use only the latched values thereafter.
REQ-018 The block SHALL treat the cycle with request high and count == WAIT_CYCLES as the completion cycle; the counter returns to 0 on the next edge.
REQ-019 The block SHALL treat request still high in the cycle after completion as a new transfer, so that waitrequest is high again for WAIT_CYCLES cycles.
REQ-020 On a read, the block SHALL load readdata with mem[latched index] on every pending cycle, so that readdata is valid in the completion cycle; latency is WAIT_CYCLES cycles from the request.
REQ-021 The block SHALL hold readdata after completion until the next read completes; writes SHALL NOT alter readdata.
REQ-022 On a write, the block SHALL update only the enabled byte lanes, at the completion-cycle edge; byteenable 4'b0000 SHALL leave memory unchanged.
REQ-023 A read to an address just written SHALL return the new data; there are no bypass hazards because the write commits before the next transfer begins.
REQ-024 If read and write are high together, the block SHALL perform the write only, keep readdata unchanged, and set protocol_error.
REQ-025 If address, read, write, byteenable or writedata changes while waitrequest is high, the block SHALL set protocol_error and complete the transfer using the latched values.
REQ-026 If address[1:0] != 0, the block SHALL set protocol_error and access the word index with the low bits ignored.
REQ-027 If address is outside [BASE_ADDR, BASE_ADDR + 4*2^ADDR_WIDTH), the block SHALL still complete the transfer with normal waitrequest timing, return 0 on a read, ignore a write, and set decode_error.
REQ-028 A request dropped before completion SHALL abort the transfer: the counter clears, memory is unchanged, and protocol_error is set.

Reset
REQ-029 When reset == 0 at an edge, the block SHALL clear count, readdata, protocol_error and decode_error to 0; waitrequest follows REQ-016.
REQ-030 A reset asserted mid-transfer SHALL abort the transfer; a pending write SHALL NOT commit.
REQ-031 Reset SHALL NOT initialise memory contents.

Verification
REQ-032 With WAIT_CYCLES=2, write 32'h11223344, be=4'hF to BFC00000, then read BFC00000 -> waitrequest high 2 cycles per transfer, readdata 32'h11223344 in the read completion cycle.
REQ-033 Write 32'hAABBCCDD be=4'b0101 over word 32'h11223344, then read -> 32'h11BB33DD.
REQ-034 Read held high for 2 transfers back-to-back -> waitrequest pattern 1,1,0,1,1,0; both transfers return correct data.
REQ-035 Read of 32'h00000000 (outside the map) -> completes after 2 cycles, readdata 0, decode_error 1; a write there leaves all words unchanged.
REQ-036 Change address during waitrequest; separately assert read and write together -> protocol_error 1, latched-address behaviour; reset low -> both flags 0.
REQ-037 Assert reset in the second wait cycle of a write -> target word unchanged on a subsequent read.
